// File: rtl/phy_regfile_mp.sv
// +------------------------------------------------------------------------+
// | Module  : phy_regfile_mp                                               |
// | Brief   : Multi-ported physical register file with ready scoreboard.   |
// |           Optional same-cycle write bypass when PRF_BYPASS_EN is set.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module phy_regfile_mp #(
  parameter int REG_VAL_WIDTH     = 32,
  parameter int PHY_REG_NUM_WIDTH = 7,
  parameter int NUM_RD_PORTS      = 4,
  parameter int NUM_WR_PORTS      = 2
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic [NUM_RD_PORTS*PHY_REG_NUM_WIDTH-1:0] rd_phy_reg,
  output logic [NUM_RD_PORTS*REG_VAL_WIDTH-1:0]     rd_val,
  output logic [NUM_RD_PORTS-1:0]                   rd_ready,
  input  logic                                      alloc_en,
  input  logic [PHY_REG_NUM_WIDTH-1:0]              alloc_phy_reg,
  input  logic [NUM_WR_PORTS-1:0]                   wr_en,
  input  logic [NUM_WR_PORTS*PHY_REG_NUM_WIDTH-1:0] wr_phy_reg,
  input  logic [NUM_WR_PORTS*REG_VAL_WIDTH-1:0]     wr_val,
  input  logic                                      flush,
  output logic                                      wr_conflict
);

  localparam int NUM_OF_REGS = 1 << PHY_REG_NUM_WIDTH;
  localparam int PW          = PHY_REG_NUM_WIDTH;
  localparam int VW          = REG_VAL_WIDTH;

  logic [VW-1:0]          regs [NUM_OF_REGS];
  logic [NUM_OF_REGS-1:0] ready;
  logic                   conflict_next;

  always_comb begin
    conflict_next = 1'b0;
    for (int j = 0; j < NUM_WR_PORTS; j++) begin
      for (int k = j + 1; k < NUM_WR_PORTS; k++) begin
        if (wr_en[j] && wr_en[k] && (wr_phy_reg[j*PW +: PW] == wr_phy_reg[k*PW +: PW]))
          conflict_next = 1'b1;
      end
    end
  end

  // Later non-blocking assignments override earlier ones: ascending port order makes the
  // highest write port win, then alloc beats write, then flush beats alloc for ready bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_OF_REGS; i++) begin
        regs[i] <= VW'(i);
      end
      ready       <= '1;
      wr_conflict <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_WR_PORTS; k++) begin
        if (wr_en[k] && (wr_phy_reg[k*PW +: PW] != '0)) begin
          regs[wr_phy_reg[k*PW +: PW]]  <= wr_val[k*VW +: VW];
          ready[wr_phy_reg[k*PW +: PW]] <= 1'b1;
        end
      end
      if (alloc_en && (alloc_phy_reg != '0)) begin
        ready[alloc_phy_reg] <= 1'b0;
      end
      if (flush) begin
        ready <= '1;
      end
      wr_conflict <= conflict_next;
    end
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    logic [PW-1:0] idx;
    assign idx = rd_phy_reg[p*PW +: PW];

    always_comb begin
      rd_val[p*VW +: VW] = regs[idx];
      rd_ready[p]        = ready[idx];
`ifdef PRF_BYPASS_EN
      for (int j = 0; j < NUM_WR_PORTS; j++) begin
        if (wr_en[j] && (wr_phy_reg[j*PW +: PW] == idx)) begin
          rd_val[p*VW +: VW] = wr_val[j*VW +: VW];
          rd_ready[p]        = 1'b1;
        end
      end
`endif
      if (idx == '0) begin
        rd_val[p*VW +: VW] = '0;
        rd_ready[p]        = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_phy_regfile_mp.sv
// +------------------------------------------------------------------------+
// | Module  : tb_phy_regfile_mp                                            |
// | Brief   : Scoreboard bench for phy_regfile_mp (default 4R/2W, 32b).    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_phy_regfile_mp;

  localparam int VW = 32;
  localparam int PW = 7;
  localparam int NR = 4;
  localparam int NW = 2;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [NR*PW-1:0]   rd_phy_reg;
  logic [NR*VW-1:0]   rd_val;
  logic [NR-1:0]      rd_ready;
  logic               alloc_en;
  logic [PW-1:0]      alloc_phy_reg;
  logic [NW-1:0]      wr_en;
  logic [NW*PW-1:0]   wr_phy_reg;
  logic [NW*VW-1:0]   wr_val;
  logic               flush;
  logic               wr_conflict;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    int         port;
    logic [31:0] val;
    logic       rdy;
  } exp_t;

  exp_t sb[$];

  phy_regfile_mp #(
    .REG_VAL_WIDTH(VW), .PHY_REG_NUM_WIDTH(PW), .NUM_RD_PORTS(NR), .NUM_WR_PORTS(NW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rd_phy_reg(rd_phy_reg), .rd_val(rd_val),
    .rd_ready(rd_ready), .alloc_en(alloc_en), .alloc_phy_reg(alloc_phy_reg),
    .wr_en(wr_en), .wr_phy_reg(wr_phy_reg), .wr_val(wr_val), .flush(flush),
    .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_rd(input string tag, input int port, input int addr,
                           input logic [31:0] val, input logic rdy);
    exp_t e;
    rd_phy_reg[port*PW +: PW] = PW'(addr);
    e.tag = tag; e.port = port; e.val = val; e.rdy = rdy;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, "_val"}, rd_val[e.port*VW +: VW], e.val);
      chk({e.tag, "_rdy"}, {31'd0, rd_ready[e.port]}, {31'd0, e.rdy});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = '0; alloc_en = 1'b0; flush = 1'b0;
  endtask

  task automatic drive_wr(input int port, input int addr, input logic [31:0] val);
    wr_en[port] = 1'b1;
    wr_phy_reg[port*PW +: PW] = PW'(addr);
    wr_val[port*VW +: VW] = val;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; rd_phy_reg = '0; alloc_phy_reg = '0; wr_phy_reg = '0; wr_val = '0;
    idle();
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // reset state
    expect_rd("rst_p5", 0, 5, 32'd5, 1'b1);
    expect_rd("rst_p0", 1, 0, 32'd0, 1'b1);
    expect_rd("rst_p127", 2, 127, 32'd127, 1'b1);
    drain();
    chk("rst_conflict", {31'd0, wr_conflict}, 32'd0);

    // alloc clears ready, data unchanged
    alloc_en = 1'b1; alloc_phy_reg = 7'd9;
    step(); idle();
    expect_rd("alloc_p9", 0, 9, 32'd9, 1'b0);
    drain();

    // writeback on port 1 sets data and ready
    drive_wr(1, 9, 32'hDEAD);
    step(); idle();
    expect_rd("wr_p9", 0, 9, 32'hDEAD, 1'b1);
    drain();

    // same register on both write ports: port 1 wins, conflict pulses one cycle
    drive_wr(0, 12, 32'h11); drive_wr(1, 12, 32'h22);
    step(); idle();
    expect_rd("coll_p12", 1, 12, 32'h22, 1'b1);
    drain();
    chk("conflict_hi", {31'd0, wr_conflict}, 32'd1);
    step();
    chk("conflict_lo", {31'd0, wr_conflict}, 32'd0);

    // alloc beats write for ready; data still written
    alloc_en = 1'b1; alloc_phy_reg = 7'd20; drive_wr(0, 20, 32'h7);
    step(); idle();
    expect_rd("prio_p20", 0, 20, 32'h7, 1'b0);
    drain();

    // flush beats alloc and sets every ready bit
    alloc_en = 1'b1; alloc_phy_reg = 7'd21; drive_wr(0, 21, 32'h8); flush = 1'b1;
    step(); idle();
    expect_rd("flush_p21", 0, 21, 32'h8, 1'b1);
    expect_rd("flush_p20", 1, 20, 32'h7, 1'b1);
    drain();

    // P0 is hard zero
    drive_wr(0, 0, 32'hFF); alloc_en = 1'b1; alloc_phy_reg = 7'd0;
    step(); idle();
    expect_rd("p0_guard", 3, 0, 32'd0, 1'b1);
    drain();

    // same-cycle read of a register under write, with an alloc of it too
    drive_wr(1, 33, 32'hABCD); alloc_en = 1'b1; alloc_phy_reg = 7'd33;
`ifdef PRF_BYPASS_EN
    expect_rd("byp_same", 2, 33, 32'hABCD, 1'b1);
`else
    expect_rd("byp_same", 2, 33, 32'd33, 1'b1);
`endif
    drain();
    step(); idle();
    expect_rd("byp_next", 2, 33, 32'hABCD, 1'b0);
    drain();

    // writes spread over both ports, read back on all four ports
    for (int i = 0; i < 4; i++) begin
      drive_wr(i % 2, 50 + i, 32'h1111 * (i + 1));
      step(); idle();
    end
    for (int i = 0; i < 4; i++) begin
      expect_rd($sformatf("multi_p%0d", 50 + i), 3 - i, 50 + i, 32'h1111 * (i + 1), 1'b1);
    end
    drain();

    // mid-operation reset re-initialises immediately
    alloc_en = 1'b1; alloc_phy_reg = 7'd40;
    step(); idle();
    reset_n = 1'b0;
    expect_rd("mrst_p40", 0, 40, 32'd40, 1'b1);
    expect_rd("mrst_p9", 1, 9, 32'd9, 1'b1);
    expect_rd("mrst_p12", 2, 12, 32'd12, 1'b1);
    drain();
    step();
    reset_n = 1'b1;
    step();
    expect_rd("post_rst_p33", 0, 33, 32'd33, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
